// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter driving a chain of load-enabled bit flops (falling-edge clocked).
// Optional build macro PARITY_EN appends one even-parity bit after the data bits.
module serial_word_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             stall_i,
    input  logic             abort_i,
    output logic             sout_o,
    output logic             sload_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sout_q, sout_d;
    logic               sload_q, sload_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               next_bit;
    logic [WIDTH-1:0]   shifted;
    logic               last_bit;

    assign next_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign shifted  = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = sout_q;
        sload_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif

        // abort wins over stall and over the done pulse of a word in flight
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shreg_d  = din_i;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = SHIFT;
`ifdef PARITY_EN
                        parity_d = ^din_i;
`endif
                    end
                end
                SHIFT: begin
                    if (!stall_i) begin
                        sout_d  = next_bit;
                        sload_d = 1'b1;
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_bit) begin
`ifdef PARITY_EN
                            state_d = PAR;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    if (!stall_i) begin
                        sout_d  = parity_q;
                        sload_d = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
                DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    // NOTE: the data shift register is reset too, since its reset value is architecturally defined.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
            sload_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sout_q   <= sout_d;
            sload_q  <= sload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign sout_o  = sout_q;
    assign sload_o = sload_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-based transaction model.
module tb_serial_word_tx;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, stall, abort;
    logic [W-1:0] din;
    logic         sout_l, sload_l, busy_l, done_l;
    logic         sout_m, sload_m, busy_m, done_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start_i(start), .din_i(din), .stall_i(stall), .abort_i(abort),
        .sout_o(sout_l), .sload_o(sload_l), .busy_o(busy_l), .done_o(done_l)
    );

    serial_word_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start_i(start), .din_i(din), .stall_i(stall), .abort_i(abort),
        .sout_o(sout_m), .sload_o(sload_m), .busy_o(busy_m), .done_o(done_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a word is a queue of bit indices still to send (index W = parity bit).
    int           q[$];
    logic [W-1:0] m_word = '0;
    bit           m_active = 0;
    bit           m_sout_l = 0, m_sout_m = 0, m_sload = 0, m_busy = 0, m_done = 0;
    int           edge_n = 0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_active = 0; m_sout_l = 0; m_sout_m = 0; m_sload = 0; m_busy = 0; m_done = 0;
        end else begin
            edge_n++;
            m_done = 0;
            if (!m_active) begin
                m_sload = 0;
                if (start) begin
                    m_word = din;
                    q.delete();
                    for (int i = 0; i < W + P; i++) q.push_back(i);
                    m_active = 1;
                    m_busy   = 1;
                end
            end else if (abort) begin
                q.delete();
                m_active = 0; m_sload = 0; m_busy = 0;
            end else if (q.size() == 0) begin
                m_active = 0; m_sload = 0; m_busy = 0; m_done = 1;
            end else if (stall) begin
                m_sload = 0;
            end else begin
                int idx;
                idx = q.pop_front();
                m_sload = 1;
                if (idx == W) begin
                    m_sout_l = ^m_word;
                    m_sout_m = ^m_word;
                end else begin
                    m_sout_l = m_word[idx];
                    m_sout_m = m_word[W-1-idx];
                end
            end
        end
    end

    bit cmp_en = 0;
    always @(posedge clk) begin
        if (cmp_en && !rst) begin
            check("sout_lsb",  sout_l,  m_sout_l);
            check("sload_lsb", sload_l, m_sload);
            check("busy_lsb",  busy_l,  m_busy);
            check("done_lsb",  done_l,  m_done);
            check("sout_msb",  sout_m,  m_sout_m);
            check("sload_msb", sload_m, m_sload);
            check("busy_msb",  busy_m,  m_busy);
            check("done_msb",  done_m,  m_done);
        end
    end

    // Recorder of observed bits and event timing, used by the literal expectations.
    logic [15:0] rec_l = '0, rec_m = '0;
    int rec_n = 0, busy_cnt = 0, done_cnt = 0, done_edge = 0, start_edge = 0;

    always @(posedge clk) begin
        if (sload_l === 1'b1 && rec_n < 16) begin
            rec_l[rec_n] = sout_l;
            rec_m[rec_n] = sout_m;
            rec_n++;
        end
        if (busy_l === 1'b1) busy_cnt++;
        if (done_l === 1'b1) begin
            done_cnt++;
            done_edge = edge_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_word(input logic [W-1:0] w);
        rec_n = 0; rec_l = '0; rec_m = '0; busy_cnt = 0;
        din = w;
        start = 1'b1;
        start_edge = edge_n + 1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0, k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < 60) begin
            step();
            k++;
        end
        check("done_seen", done_cnt - n0, 1);
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (rec_n < n && k < 60) begin
            step();
            k++;
        end
        check("bits_seen", rec_n, n);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0; din = '0;
        #7;
        check("rst_sout",  sout_l,  0);
        check("rst_sload", sload_l, 0);
        check("rst_busy",  busy_l,  0);
        check("rst_done",  done_m,  0);
        step();
        rst = 1'b0;
        cmp_en = 1;
        step();

        // Plain word, both bit orders
        begin_word(8'h96);
        wait_done();
        check("s1_bits_lsb", rec_l[7:0], 8'b1001_0110);
        check("s2_bits_msb", rec_m[7:0], 8'b0110_1001);
        check("s1_nbits", rec_n, W + P);
        check("s1_done_edge", done_edge - start_edge, 9 + P);
        check("s1_busy_cycles", busy_cnt, 9 + P);
        step(); step();

        // Stall for three cycles after the second bit
        begin_word(8'h96);
        wait_bits(2);
        stall = 1'b1;
        step(); step(); step();
        stall = 1'b0;
        wait_done();
        check("s3_bits_lsb", rec_l[7:0], 8'h96);
        check("s3_nbits", rec_n, W + P);
        check("s3_done_edge", done_edge - start_edge, 12 + P);
        step();

        // Abort after the fourth bit, restart one cycle later
        begin_word(8'h96);
        wait_bits(4);
        d0 = done_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("s4_abort_busy", busy_l, 0);
        check("s4_abort_sload", sload_l, 0);
        begin_word(8'hB1);
        check("s4_no_done", done_cnt, d0);
        wait_done();
        check("s4_new_lsb", rec_l[7:0], 8'hB1);
        check("s4_new_msb", rec_m[7:0], 8'h8D);
        check("s4_done_edge", done_edge - start_edge, 9 + P);
        step();

        // Asynchronous reset mid-word
        begin_word(8'h96);
        wait_bits(3);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("s5_rst_sout",  sout_l,  0);
        check("s5_rst_sload", sload_l, 0);
        check("s5_rst_busy",  busy_l,  0);
        check("s5_rst_busy_m", busy_m, 0);
        #1 rst = 1'b0;
        step(); step(); step();
        check("s5_no_done", done_cnt, d0);

        // start held through busy and DONE; din changes mid-word ignored
        rec_n = 0; rec_l = '0; busy_cnt = 0;
        din = 8'h96;
        start = 1'b1;
        start_edge = edge_n + 1;
        step();
        din = 8'hFF;
        wait_done();
        check("s5_held_bits", rec_l[7:0], 8'h96);
        check("s5_held_done_edge", done_edge - start_edge, 9 + P);
        check("s5_done_busy", busy_l, 0);
        check("s5_done_pulse", done_l, 1);
        rec_n = 0; rec_l = '0;
        step();
        check("s5_reaccept_busy", busy_l, 1);
        check("s5_reaccept_done", done_l, 0);
        start = 1'b0;
        wait_done();
        check("s5_second_word", rec_l[7:0], 8'hFF);
        check("s5_second_done_edge", done_edge - start_edge, 2 * (9 + P) + 1);
        step();

`ifdef PARITY_EN
        begin_word(8'h96);
        wait_done();
        check("s6_par96_lsb", rec_l[8], 0);
        check("s6_par96_msb", rec_m[8], 0);
        begin_word(8'h97);
        wait_done();
        check("s6_par97_lsb", rec_l[8], 1);
        check("s6_par97_msb", rec_m[8], 1);
        check("s6_done_edge", done_edge - start_edge, 10);
`else
        begin_word(8'h97);
        wait_done();
        check("s6_bits_lsb", rec_l[7:0], 8'h97);
        check("s6_bits_msb", rec_m[7:0], 8'hE9);
        check("s6_nbits", rec_n, 8);
        check("s6_done_edge", done_edge - start_edge, 9);
`endif
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-in, serial-out transmitter. It produces the d/load bit stream that drives a chain of 1-bit load-enabled storage flops.
- Captures a WIDTH-bit word on a start handshake.
- Emits the word one bit per cycle on sout, with a qualifying sload strobe.
- Signals completion with a one-cycle done pulse.
- Sits between the datapath's word registers and the bit-serial register/shift elements of the processor.

Parameters:
WIDTH, 8, number of data bits per word (>= 2)
LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first

Ports:
clk  input  1  system clock; all state updates on the falling edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to transmit din; sampled only in IDLE
din  input  WIDTH  word to transmit; captured on the accepting edge
stall  input  1  pause shifting while high (SHIFT/PAR states only)
abort  input  1  synchronous cancel of the current word
sout  output  1  serial data bit (registered)
sload  output  1  high when sout carries a valid bit (registered)
busy  output  1  high from word acceptance until done/abort
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Interface: one clock, clk, updating on its falling edge. Reset rst is asynchronous and active-high; it forces reset values immediately, regardless of clk.
- Reset values: state=IDLE, sout=0, sload=0, busy=0, done=0, bit counter=0, shift register=0.
- State machine: IDLE, SHIFT, PAR (present only with PARITY_EN), DONE.
- IDLE:
  - busy=0, sload=0.
  - Edge E0 with start=1: capture din into the shift register, clear the counter, set busy=1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - Each edge with stall=0: sout <= next bit (LSB or MSB per LSB_FIRST), sload <= 1, shift the register, counter++.
  - Each edge with stall=1: sload <= 0; sout, shift register and counter hold.
  - The edge emitting bit WIDTH-1 goes to PAR (if enabled), otherwise to DONE.
- Unstalled timing: bits appear after edges E1..E_WIDTH, with sload=1 on each.
- DONE (one edge):
  - sload <= 0, done <= 1, busy <= 0, go to IDLE.
  - done clears on the following edge.
  - start is ignored while in DONE.
  - Earliest next acceptance is edge E_WIDTH+2 (no-parity build). A start held high therefore sends back-to-back words with one idle bit slot between them.
- start while busy: ignored; din changes while busy have no effect.
- abort=1 in SHIFT, PAR or DONE:
  - Next edge: go to IDLE, sload=0, busy=0, done=0, counter=0.
  - No done pulse is generated.
  - abort has priority over stall.
- abort in IDLE: no effect; start is still accepted on that edge.
- rst mid-word: outputs return to reset values immediately. No done pulse; the word is lost.
- sout holds its last value when sload=0. Consumers must qualify sout with sload.

Optional Feature:
Macro PARITY_EN.
- Defined: after the last data bit the FSM enters PAR. It emits one extra bit, the even parity (XOR) of the captured word, with sload=1. stall is honoured in PAR. DONE follows, so a word occupies WIDTH+1 bit slots and done arrives one cycle later.
- Undefined: the PAR state and parity logic are absent; SHIFT goes directly to DONE.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, din=8'h96, start for 1 cycle -> sload high for 8 consecutive cycles; sout=0,1,1,0,1,0,0,1; done pulse after edge E9; busy high E0..E8.
2. LSB_FIRST=0, din=8'h96 -> sout=1,0,0,1,0,1,1,0; done timing identical to scenario 1.
3. din=8'h96, stall high 3 cycles after the 2nd bit -> sload low exactly 3 cycles; bit sequence unchanged; done delayed by 3 cycles.
4. abort asserted after the 4th bit -> next edge busy=0 and sload=0; no done pulse. A start 1 cycle later is accepted and transmits the new word fully.
5. rst pulsed asynchronously (between edges) mid-word -> all outputs 0 immediately. start held during busy and DONE -> ignored; next word is accepted only at E10.
6. PARITY_EN, din=8'h96 -> 9th bit sout=0; din=8'h97 -> 9th bit sout=1; done after edge E10.
